// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter and the load/store lane logic.
package mem_port_arbiter_pkg;

  localparam int unsigned BSLCT_W    = 4;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned ADDR_BUS_W = 32;

  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_IF_BUSY  = 2'b01,
    ST_MEM_BUSY = 2'b10,
    ST_ERR_RESP = 2'b11
  } arb_state_e;

  // Lane masks the bus accepts: single bytes, aligned halves, full word.
  localparam logic [BSLCT_W-1:0] BSLCT_B3   = 4'b1000;
  localparam logic [BSLCT_W-1:0] BSLCT_B2   = 4'b0100;
  localparam logic [BSLCT_W-1:0] BSLCT_B1   = 4'b0010;
  localparam logic [BSLCT_W-1:0] BSLCT_B0   = 4'b0001;
  localparam logic [BSLCT_W-1:0] BSLCT_HI   = 4'b1100;
  localparam logic [BSLCT_W-1:0] BSLCT_LO   = 4'b0011;
  localparam logic [BSLCT_W-1:0] BSLCT_WORD = 4'b1111;

  function automatic logic bslct_is_legal(input logic [BSLCT_W-1:0] slct);
    case (slct)
      BSLCT_B3, BSLCT_B2, BSLCT_B1, BSLCT_B0,
      BSLCT_HI, BSLCT_LO, BSLCT_WORD: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_bslct_legal_chk.sv
// Combinational byte-select legality check, shared with the store path.
module bslct_legal_chk
  import mem_port_arbiter_pkg::*;
(
  input  logic [BSLCT_W-1:0] byte_slct,
  output logic               legal_c
);

  assign legal_c = bslct_is_legal(byte_slct);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the external memory port between instruction fetch and the load/store unit,
// sequencing one req/ack bus cycle at a time with MEM priority, IF anti-starvation and timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_MEM_STREAK = 4,
  parameter int unsigned TIMEOUT        = 64
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [DATA_W-1:0]  if_rdata,
  output logic               if_ready,
  output logic               if_err,

  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [BSLCT_W-1:0] mem_byte_slct,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_ready,
  output logic               mem_err,

  output logic               bus_req,
  output logic               bus_we,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [BSLCT_W-1:0] bus_byte_slct,
  output logic [DATA_W-1:0]  bus_wdata,
  input  logic [DATA_W-1:0]  bus_rdata,
  input  logic               bus_ack,

  output logic               stall_if,
  output logic               stall_mem
);

  localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned STREAK_W = $clog2(MAX_MEM_STREAK + 1);

  arb_state_e          state_q, state_n;
  logic [STREAK_W-1:0] streak_q, streak_n;
  logic [TMO_W-1:0]    tmo_q, tmo_n;

  logic                bus_req_q, bus_req_n;
  logic                bus_we_q, bus_we_n;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_n;
  logic [BSLCT_W-1:0]  bus_slct_q, bus_slct_n;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_n;

  logic [DATA_W-1:0]   if_rdata_q, if_rdata_n;
  logic                if_ready_q, if_ready_n;
  logic                if_err_q, if_err_n;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_n;
  logic                mem_ready_q, mem_ready_n;
  logic                mem_err_q, mem_err_n;

  logic                mem_slct_legal;
  logic                if_forced;
  logic                cmpl_gap;

  bslct_legal_chk u_bslct_chk (
    .byte_slct (mem_byte_slct),
    .legal_c   (mem_slct_legal)
  );

  assign if_forced = if_req && (streak_q == STREAK_W'(MAX_MEM_STREAK));
  // A ready pulse marks the mandatory idle gap; the finished requester's req is still up.
  assign cmpl_gap  = if_ready_q | mem_ready_q;

  // Next-state and next-output decision.
  always_comb begin
    state_n     = state_q;
    streak_n    = streak_q;
    tmo_n       = tmo_q;
    bus_req_n   = bus_req_q;
    bus_we_n    = bus_we_q;
    bus_addr_n  = bus_addr_q;
    bus_slct_n  = bus_slct_q;
    bus_wdata_n = bus_wdata_q;
    if_rdata_n  = if_rdata_q;
    if_ready_n  = 1'b0;
    if_err_n    = 1'b0;
    mem_rdata_n = mem_rdata_q;
    mem_ready_n = 1'b0;
    mem_err_n   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_n = '0;
        if (!if_req) streak_n = '0;
        if (!cmpl_gap) begin
          if (mem_req && !mem_slct_legal) begin
            state_n     = ST_ERR_RESP;
            mem_ready_n = 1'b1;
            mem_err_n   = 1'b1;
            mem_rdata_n = '0;
          end else if (mem_req && !if_forced) begin
            state_n     = ST_MEM_BUSY;
            bus_req_n   = 1'b1;
            bus_we_n    = mem_we;
            bus_addr_n  = mem_addr;
            bus_slct_n  = mem_byte_slct;
            bus_wdata_n = mem_wdata;
            if (if_req) streak_n = streak_q + STREAK_W'(1);
          end else if (if_req) begin
            state_n     = ST_IF_BUSY;
            bus_req_n   = 1'b1;
            bus_we_n    = 1'b0;
            bus_addr_n  = if_addr;
            bus_slct_n  = BSLCT_WORD;
            bus_wdata_n = '0;
            streak_n    = '0;
          end
        end
      end

      ST_IF_BUSY, ST_MEM_BUSY: begin
        if (bus_ack || (tmo_q == TMO_W'(TIMEOUT - 1))) begin
          state_n   = ST_IDLE;
          bus_req_n = 1'b0;
          tmo_n     = '0;
          if (state_q == ST_IF_BUSY) begin
            if_ready_n = 1'b1;
            if_err_n   = !bus_ack;
            if_rdata_n = bus_ack ? bus_rdata : '0;
          end else begin
            mem_ready_n = 1'b1;
            mem_err_n   = !bus_ack;
            mem_rdata_n = (bus_ack && !bus_we_q) ? bus_rdata : '0;
          end
        end else begin
          tmo_n = tmo_q + TMO_W'(1);
        end
      end

      ST_ERR_RESP: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n   = ST_IDLE;
        bus_req_n = 1'b0;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_slct_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      mem_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      streak_q    <= streak_n;
      tmo_q       <= tmo_n;
      bus_req_q   <= bus_req_n;
      bus_we_q    <= bus_we_n;
      bus_addr_q  <= bus_addr_n;
      bus_slct_q  <= bus_slct_n;
      bus_wdata_q <= bus_wdata_n;
      if_rdata_q  <= if_rdata_n;
      if_ready_q  <= if_ready_n;
      if_err_q    <= if_err_n;
      mem_rdata_q <= mem_rdata_n;
      mem_ready_q <= mem_ready_n;
      mem_err_q   <= mem_err_n;
    end
  end

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_byte_slct = bus_slct_q;
  assign bus_wdata     = bus_wdata_q;
  assign if_rdata      = if_rdata_q;
  assign if_ready      = if_ready_q;
  assign if_err        = if_err_q;
  assign mem_rdata     = mem_rdata_q;
  assign mem_ready     = mem_ready_q;
  assign mem_err       = mem_err_q;

  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected grants/responses,
// a negedge monitor pops and compares whenever the DUT starts a bus cycle or pulses ready.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  slct;
    logic [31:0] wdata;
  } grant_t;

  typedef struct packed {
    logic        is_mem;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, bus_ack;
  logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [3:0]  mem_byte_slct;
  logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_ready, if_err, mem_ready, mem_err;
  logic        bus_req, bus_we, stall_if, stall_mem;
  logic [3:0]  bus_byte_slct;

  int          checks = 0;
  int          errors = 0;
  grant_t      exp_grants[$];
  resp_t       exp_resps[$];

  int          ack_delay = 0;
  logic [31:0] ack_data  = '0;
  logic        late_ack  = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_MEM_STREAK(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byte_slct(mem_byte_slct), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byte_slct(bus_byte_slct), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_grant(input logic is_mem, input logic we, input logic [31:0] addr,
                            input logic [3:0] slct, input logic [31:0] wdata);
    grant_t g;
    g = '{is_mem: is_mem, we: we, addr: addr, slct: slct, wdata: wdata};
    exp_grants.push_back(g);
  endtask

  task automatic push_resp(input logic is_mem, input logic err, input logic [31:0] rdata);
    resp_t r;
    r = '{is_mem: is_mem, err: err, rdata: rdata};
    exp_resps.push_back(r);
  endtask

  task automatic chk_resp(input logic is_mem, input logic err, input logic [31:0] rdata);
    resp_t r;
    if (exp_resps.size() == 0) begin
      check(is_mem ? "unexpected_mem_ready" : "unexpected_if_ready", 64'd1, 64'd0);
    end else begin
      r = exp_resps.pop_front();
      check("resp_port", 64'(is_mem), 64'(r.is_mem));
      check("resp_err", 64'(err), 64'(r.err));
      check("resp_rdata", 64'(rdata), 64'(r.rdata));
    end
  endtask

  // Bus responder: acks the ack_delay-th busy cycle; late_ack forces a stray ack.
  initial begin
    int busy_cnt;
    busy_cnt  = 0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_ack = 1'b0;
      if (late_ack) begin
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD0BAD;
      end else if (bus_req && ack_delay != 0) begin
        if (busy_cnt + 1 == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = ack_data;
          busy_cnt  = 0;
        end else begin
          busy_cnt++;
        end
      end else begin
        busy_cnt = 0;
      end
    end
  end

  // Monitor: compares every bus-cycle start and every ready pulse against the scoreboard.
  initial begin
    logic   prev_req;
    grant_t g;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus_req && !prev_req) begin
          if (exp_grants.size() == 0) begin
            check("unexpected_grant", 64'(bus_addr), 64'd0);
          end else begin
            g = exp_grants.pop_front();
            check("grant_addr", 64'(bus_addr), 64'(g.addr));
            check("grant_we_slct", 64'({bus_we, bus_byte_slct}), 64'({g.we, g.slct}));
            if (g.is_mem) check("grant_wdata", 64'(bus_wdata), 64'(g.wdata));
          end
        end
        if (if_ready)  chk_resp(1'b0, if_err, if_rdata);
        if (mem_ready) chk_resp(1'b1, mem_err, mem_rdata);
      end
      prev_req = rst ? bus_req : 1'b0;
    end
  end

  task automatic wait_ready(input logic want_mem, input int budget, output int cyc,
                            output logic prev_bus_req);
    logic last;
    cyc  = -1;
    last = bus_req;
    prev_bus_req = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (want_mem ? mem_ready : if_ready) begin
        cyc = c;
        prev_bus_req = last;
        break;
      end
      last = bus_req;
    end
    if (cyc < 0) check(want_mem ? "mem_ready_wait" : "if_ready_wait", 64'd0, 64'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          n;
    logic        pbr;
    logic [5:0]  req_bits, stall_bits, rdy_bits;
    logic        seen;

    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_byte_slct = '0; mem_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_readies", 64'({if_ready, if_err, mem_ready, mem_err}), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("rst_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Lone fetch, ack on third busy cycle
    ack_delay = 3; ack_data = 32'h8C220004;
    push_grant(1'b0, 1'b0, 32'h00400010, 4'b1111, '0);
    push_resp(1'b0, 1'b0, 32'h8C220004);
    if_req = 1'b1; if_addr = 32'h00400010;
    req_bits = '0; stall_bits = '0; rdy_bits = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_bits[c]   = bus_req;
      stall_bits[c] = stall_if;
      rdy_bits[c]   = if_ready;
      if (c == 1) check("fetch_slct", 64'(bus_byte_slct), 64'hF);
      if (if_ready) begin
        next_cycle();
        if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    check("fetch_bus_req_cycles", 64'(req_bits), 64'b001110);
    check("fetch_stall_if_cycles", 64'(stall_bits), 64'b001111);
    check("fetch_ready_cycle", 64'(rdy_bits), 64'b010000);
    next_cycle();

    // Simultaneous: MEM store first, IF after the idle gap
    ack_delay = 1; ack_data = 32'h12345678;
    push_grant(1'b1, 1'b1, 32'h10010000, 4'b0011, 32'h0000BEEF);
    push_grant(1'b0, 1'b0, 32'h00400020, 4'b1111, '0);
    push_resp(1'b1, 1'b0, 32'h0);
    push_resp(1'b0, 1'b0, 32'h12345678);
    if_req = 1'b1; if_addr = 32'h00400020;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10010000;
    mem_byte_slct = 4'b0011; mem_wdata = 32'h0000BEEF;
    @(negedge clk);
    check("simul_stall_mem", 64'({stall_mem, stall_if}), 64'b11);
    wait_ready(1'b1, 10, cyc, pbr);
    check("simul_mem_latency", 64'(cyc), 64'd1);
    next_cycle();
    mem_req = 1'b0; mem_we = 1'b0;
    wait_ready(1'b0, 10, cyc, pbr);
    check("simul_if_after_gap", 64'(cyc), 64'd2);
    next_cycle();
    if_req = 1'b0;
    repeat (2) next_cycle();

    // Starvation: four MEM grants, then IF, then MEM again
    ack_delay = 1; ack_data = 32'hCAFE0001;
    for (int i = 0; i < 4; i++) push_grant(1'b1, 1'b0, 32'h10010040, 4'b1111, 32'h11112222);
    push_grant(1'b0, 1'b0, 32'h00400100, 4'b1111, '0);
    push_grant(1'b1, 1'b0, 32'h10010040, 4'b1111, 32'h11112222);
    for (int i = 0; i < 4; i++) push_resp(1'b1, 1'b0, 32'hCAFE0001);
    push_resp(1'b0, 1'b0, 32'hCAFE0001);
    push_resp(1'b1, 1'b0, 32'hCAFE0001);
    if_req = 1'b1; if_addr = 32'h00400100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10010040;
    mem_byte_slct = 4'b1111; mem_wdata = 32'h11112222;
    n = 0; cyc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_ready) n++;
      if (n == 5) begin
        cyc = c;
        break;
      end
    end
    next_cycle();
    mem_req = 1'b0; if_req = 1'b0;
    check("starve_mem_count", 64'(n), 64'd5);
    check("starve_fifth_mem_cycle", 64'(cyc), 64'd17);
    repeat (2) next_cycle();

    // Illegal lane mask: error response, no bus cycle
    push_resp(1'b1, 1'b1, 32'h0);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10010044; mem_byte_slct = 4'b0110;
    @(negedge clk);
    check("illegal_no_bus_c0", 64'(bus_req), 64'd0);
    wait_ready(1'b1, 5, cyc, pbr);
    check("illegal_ready_latency", 64'(cyc), 64'd0);
    check("illegal_no_bus_c1", 64'(bus_req), 64'd0);
    next_cycle();
    mem_req = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus_req;
    end
    check("illegal_bus_quiet", 64'(seen), 64'd0);
    next_cycle();

    // Timeout on a fetch, then a stray late ack
    ack_delay = 0;
    push_grant(1'b0, 1'b0, 32'h00400200, 4'b1111, '0);
    push_resp(1'b0, 1'b1, 32'h0);
    if_req = 1'b1; if_addr = 32'h00400200;
    wait_ready(1'b0, 80, cyc, pbr);
    check("timeout_ready_cycle", 64'(cyc), 64'd65);
    check("timeout_bus_req_before", 64'(pbr), 64'd1);
    check("timeout_bus_req_dropped", 64'(bus_req), 64'd0);
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    late_ack = 1'b1;
    next_cycle();
    late_ack = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= if_ready | mem_ready | bus_req;
    end
    check("late_ack_ignored", 64'(seen), 64'd0);

    // Reset in the middle of a MEM cycle
    ack_delay = 0;
    push_grant(1'b1, 1'b0, 32'h10010080, 4'b1100, 32'h0);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10010080;
    mem_byte_slct = 4'b1100; mem_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("midrst_busy", 64'(bus_req), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_bus_req_async", 64'(bus_req), 64'd0);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= mem_ready | if_ready | bus_req;
    end
    check("midrst_no_ready", 64'(seen), 64'd0);

    check("grants_left", 64'(exp_grants.size()), 64'd0);
    check("resps_left", 64'(exp_resps.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between instruction fetch (IF) and the MEM-stage load/store unit.
- Arbitrates between the two, sequences each multi-cycle bus transaction with a req/ack handshake, and returns raw read words. The MEM word then goes to the load-alignment logic (byte/half extraction).
- Generates pipeline stall signals and enforces IF anti-starvation and a bus timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (must be 32; byte_slct is 4 lanes)
MAX_MEM_STREAK, 4, consecutive MEM grants allowed while IF waits before IF is forced
TIMEOUT, 64, busy cycles without bus_ack before abort (counter width = clog2(TIMEOUT+1))

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
if_req  in  1  fetch request, held with if_addr until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid with if_ready
if_ready  out  1  one-cycle completion pulse
if_err  out  1  qualifies if_ready: timeout abort
mem_req  in  1  load/store request, held stable until mem_ready
mem_we  in  1  1 = store
mem_addr  in  ADDR_W  access address
mem_byte_slct  in  4  lane mask
mem_wdata  in  DATA_W  store data (lanes pre-positioned)
mem_rdata  out  DATA_W  raw read word, valid with mem_ready
mem_ready  out  1  one-cycle completion pulse
mem_err  out  1  qualifies mem_ready: illegal mask or timeout
bus_req  out  1  bus cycle active
bus_we  out  1  bus write
bus_addr  out  ADDR_W  bus address
bus_byte_slct  out  4  bus lane mask
bus_wdata  out  DATA_W  bus write data
bus_rdata  in  DATA_W  bus read data, sampled on bus_ack
bus_ack  in  1  bus completion, single cycle
stall_if  out  1  if_req & ~if_ready (combinational)
stall_mem  out  1  mem_req & ~mem_ready (combinational)

Behaviour:
- Reset (rst=0, async): state IDLE; all registered outputs 0; streak and timeout counters 0. Reset mid-transaction abandons it with no ready pulse.
- States: IDLE, IF_BUSY, MEM_BUSY, ERR_RESP.
- IDLE grant priority, evaluated each cycle:
  - mem_req with illegal mask -> ERR_RESP. Legal masks are 1000, 0100, 0010, 0001, 1100, 0011, 1111.
  - mem_req legal, and not (if_req and streak==MAX_MEM_STREAK) -> MEM_BUSY.
  - else if_req -> IF_BUSY.
  - else stay in IDLE.
- On grant, register bus_* (all outputs of registers):
  - IF grant: bus_we=0, bus_byte_slct=1111, bus_addr=if_addr.
  - MEM grant: bus_we=mem_we, bus_byte_slct=mem_byte_slct, bus_addr=mem_addr, bus_wdata=mem_wdata.
  - bus_req=1 from the cycle after the grant decision.
- BUSY with bus_ack=1:
  - Capture bus_rdata into the requester's rdata (MEM writes return rdata=0).
  - Pulse that requester's ready for one cycle; err=0.
  - Drop bus_req; return to IDLE.
- Minimum latency: request seen in cycle 0, bus_req in cycle 1, ack in cycle 1, ready in cycle 2.
- No back-to-back bus cycles: at least one IDLE cycle with bus_req=0 between transactions.
- Timeout: counter increments each BUSY cycle without ack. Reaching TIMEOUT drops bus_req and pulses ready+err with rdata=0. A bus_ack arriving after an abort is ignored.
- ERR_RESP: one cycle; mem_ready=1, mem_err=1, mem_rdata=0, no bus activity; then IDLE.
- Streak counter:
  - Increments on a MEM grant while if_req=1; saturates at MAX_MEM_STREAK.
  - Clears on an IF grant, or when if_req=0 in IDLE.
- Grants are non-preemptive. A request raised while BUSY waits for IDLE.
- Requester dropping req before its ready pulse is a protocol violation; the arbiter still completes the bus cycle.

Decomposition:
- Shared defines header:
  - state encoding (2-bit)
  - legal byte-select mask constants, shared with the load-alignment logic
  - byte-select width, reg-data width, address bus width
  - active-low reset level constant
- One natural sub-module: bslct_legal_chk, a combinational 4-bit legality check, reusable by the store path.

Test Plan:
- Reset mid-transaction: assert rst=0 during MEM_BUSY -> bus_req=0 that cycle; no mem_ready after release.
- Lone fetch: if_req=1, if_addr=0x00400010, ack after 3 cycles with bus_rdata=0x8C220004 -> bus_req=1 for cycles 1–3, bus_byte_slct=1111, if_ready pulse in cycle 4, if_rdata=0x8C220004, stall_if high for cycles 0–3.
- Simultaneous requests: if_req and mem_req (store, addr 0x10010000, mask 0011, wdata 0x0000BEEF) in the same cycle -> MEM served first with bus_we=1 and bus_byte_slct=0011; IF served after one idle cycle.
- Starvation: mem_req held continuously and if_req high, ack=1 immediately -> exactly 4 MEM grants, then one IF grant, then the streak restarts.
- Illegal mask: mem_byte_slct=0110 -> bus_req never asserts; mem_ready=1 and mem_err=1 on the next cycle.
- Timeout: IF grant with bus_ack held 0 for 64 busy cycles -> if_ready=1, if_err=1, if_rdata=0, bus_req drops; a late bus_ack 2 cycles later causes no ready pulse.
